// File: rtl/nine_bit_divider.sv
// nine_bit_divider: sequential restoring divider, one quotient bit per clock.
// Each trial subtraction uses a WIDTH+1 bit two's-complement subtract path:
// the divisor is complemented and the carry-in is 1.
// A Run/Done handshake matches the shift-add multiplier.
// Optional feature: define NINE_BIT_DIVIDER_SIGNED_EN for two's-complement operands.
module nine_bit_divider #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Run,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   localparam int            CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             divz_q, divz_d;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic             r_msb_unused;

`ifdef NINE_BIT_DIVIDER_SIGNED_EN
   logic dvd_neg_q, dvd_neg_d;
   logic dvs_neg_q, dvs_neg_d;

   // Two's-complement negation: the same complement-and-carry-in trick as the subtractor
   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction
`endif

   // The partial remainder never exceeds the divisor, so its top bit is always 0 between iterations
   assign r_msb_unused = r_q[WIDTH];

   // Shift {R,Q} left and perform the trial subtraction R - {0,D}
   assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign trial   = r_shift + ~{1'b0, d_q} + (WIDTH+1)'(1);

   // Next-state and datapath logic for the whole divide sequence
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      divz_d  = divz_q;
`ifdef NINE_BIT_DIVIDER_SIGNED_EN
      dvd_neg_d = dvd_neg_q;
      dvs_neg_d = dvs_neg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (Run) begin
               if (Divisor != '0) begin
                  q_d     = Dividend;
                  d_d     = Divisor;
                  r_d     = '0;
`ifdef NINE_BIT_DIVIDER_SIGNED_EN
                  dvd_neg_d = Dividend[WIDTH-1];
                  dvs_neg_d = Divisor[WIDTH-1];
`endif
                  state_d = S_LOAD;
               end else begin
                  quot_d  = '1;
                  rem_d   = Dividend;
                  divz_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_LOAD: begin
            divz_d  = 1'b0;
            cnt_d   = '0;
`ifdef NINE_BIT_DIVIDER_SIGNED_EN
            if (dvd_neg_q) q_d = negate(q_q);
            if (dvs_neg_q) d_d = negate(d_q);
`endif
            state_d = S_CALC;
         end
         S_CALC: begin
            if (!trial[WIDTH]) begin
               r_d = trial;
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = r_shift;
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) state_d = S_FIX;
         end
         S_FIX: begin
`ifdef NINE_BIT_DIVIDER_SIGNED_EN
            quot_d = (dvd_neg_q ^ dvs_neg_q) ? negate(q_q) : q_q;
            rem_d  = dvd_neg_q ? negate(r_q[WIDTH-1:0]) : r_q[WIDTH-1:0];
`else
            quot_d = q_q;
            rem_d  = r_q[WIDTH-1:0];
`endif
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!Run) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_LOAD) || (state_d == S_CALC) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset clears everything at once
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         divz_q  <= 1'b0;
`ifdef NINE_BIT_DIVIDER_SIGNED_EN
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         divz_q  <= divz_d;
`ifdef NINE_BIT_DIVIDER_SIGNED_EN
         dvd_neg_q <= dvd_neg_d;
         dvs_neg_q <= dvs_neg_d;
`endif
      end
   end

   assign Quotient  = quot_q;
   assign Remainder = rem_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign DivZero   = divz_q;

endmodule

// File: doc/nine_bit_divider.md
Name: nine_bit_divider

Overview:
Sequential restoring divider, the inverse operation of the lab shift-add multiplier datapath. It reuses the 9-bit two's-complement subtract path, with complement-B and carry-in=1, for each trial subtraction. It divides an 8-bit dividend by an 8-bit divisor, one quotient bit per clock. It sits beside the multiplier under the same switch/Run top level and uses the same Run/Done handshake style.

Parameters:
WIDTH, 8, operand/quotient/remainder width; the partial-remainder register and trial subtractor are WIDTH+1 bits wide.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Run  input  1  start request; level-sampled in IDLE.
Dividend  input  WIDTH  numerator; captured when the operation starts.
Divisor  input  WIDTH  denominator; captured when the operation starts.
Quotient  output  WIDTH  result quotient, registered.
Remainder  output  WIDTH  result remainder, registered.
Busy  output  1  high in LOAD/CALC/FIX.
Done  output  1  high in DONE only.
DivZero  output  1  divisor was zero for the current result.

Behaviour:
- Reset (Reset_n=0, asynchronous, effective immediately, including mid-operation):
  - Quotient=0, Remainder=0, Busy=0, Done=0, DivZero=0.
  - Internal R register=0, iteration counter=0, state=IDLE.
- States: IDLE, LOAD, CALC, FIX, DONE.
- IDLE:
  - If Run=1 and Divisor!=0: capture Dividend into Q register, Divisor into D register, clear R; go to LOAD.
  - If Run=1 and Divisor=0: Quotient={WIDTH{1}}, Remainder=Dividend, DivZero=1; go to DONE. Done is visible after 1 edge.
- LOAD: one cycle; clears DivZero and the counter; go to CALC.
- CALC: one iteration per edge, exactly WIDTH iterations. Each iteration:
  - Shift {R,Q} left 1 bit; R's LSB takes Q's MSB.
  - Compute T = R + ~{0,D} + 1, as WIDTH+1 bits.
  - If T[WIDTH]=0: R=T and Q[0]=1. Otherwise R is unchanged and Q[0]=0 (restore).
  - After the WIDTH-th iteration go to FIX.
- FIX: copy Q to Quotient and R[WIDTH-1:0] to Remainder; go to DONE.
- Latency: capture edge k; Done=1 after edge k+WIDTH+2 (k+10 for WIDTH=8).
- DONE:
  - Done=1 and outputs are held stable.
  - Remains in DONE while Run=1. When Run=0, return to IDLE on the next edge.
  - A new operation requires Run to fall and rise again; holding Run high never restarts.
- Input changes on Dividend/Divisor after capture have no effect on the running operation.
- Run deasserting during LOAD/CALC/FIX does not abort the operation.
- Unsigned arithmetic: Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor.

Optional Feature:
Macro: NINE_BIT_DIVIDER_SIGNED_EN
- Defined: operands are two's complement.
  - LOAD takes magnitudes: negate using the subtract path if the MSB is set.
  - FIX negates Quotient if the operand signs differ, and negates Remainder if Dividend was negative.
  - Quotient truncates toward zero; Remainder takes the sign of the Dividend.
  - Overflow case -2^(WIDTH-1)/-1 yields Quotient=0x80, Remainder=0, with no flag.
  - Divide by zero behaves as in the unsigned case (Quotient all ones, Remainder=Dividend raw).
  - Latency is unchanged, because the sign fix-up is done within the LOAD and FIX cycles.
- Undefined: unsigned only; sign logic is absent.

Test Plan:
1. Dividend=100, Divisor=7, Run pulse held -> Busy high for 10 cycles, then Done=1, Quotient=14, Remainder=2, DivZero=0; Run low -> IDLE, Done=0 next edge.
2. 255/1 -> Quotient=255, Remainder=0; 5/9 -> Quotient=0, Remainder=5; 200/200 -> Quotient=1, Remainder=0.
3. Dividend=0x42, Divisor=0 -> Done after 1 edge, Quotient=0xFF, Remainder=0x42, DivZero=1; a following 9/3 clears DivZero and gives Quotient=3, Remainder=0.
4. Start 100/7, then assert Reset_n=0 during the 4th CALC cycle -> all outputs 0 immediately, state IDLE; after release with Run still high, a fresh 100/7 completes correctly.
5. Run held high through Done for 20 cycles -> exactly one operation; outputs stable. Change Dividend mid-CALC -> result unaffected.
6. (SIGNED_EN) -100/7 -> Quotient=0xF2 (-14), Remainder=0xFE (-2); 100/-7 -> Quotient=0xF2, Remainder=0x02; -128/-1 -> Quotient=0x80, Remainder=0.
